sar_search_ctrl: RTL and testbench
==================================

SAR_SEARCH_CTRL -- requirements
Module: sar_search_ctrl

Interface
REQ-001 Parameter W, default 4: width of trial/result, W >= 2.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a search; sampled only in IDLE.
REQ-005 gt  input  1  external comparator: target > trial.
REQ-006 eq  input  1  external comparator: target == trial.
REQ-007 lt  input  1  external comparator: target < trial.
REQ-008 trial  output  W  registered value driven to comparator b-input; target drives a-input.
REQ-009 busy  output  1  high while in TEST.
REQ-010 done  output  1  single-cycle pulse, high in DONE.
REQ-011 result  output  W  registered search result; valid from done, held until next accepted start.
REQ-012 err  output  1  flags not one-hot during the search; valid with done, held until next accepted start.

Function
REQ-013 FSM states: IDLE, TEST, DONE; no other states reachable.
REQ-014 IDLE: trial = 0, busy = 0, done = 0; start = 1 -> TEST, trial = 1 << (W-1), bit index k = W-1, result and err cleared.
REQ-015 start while in TEST or DONE is ignored, with no effect on state or outputs.
REQ-016 TEST: flags are sampled combinationally against the current registered trial, one decision per cycle.
REQ-017 TEST, flags not exactly one-hot: err <= 1, result <= 0 -> DONE.
REQ-018 TEST, eq = 1: result <= trial -> DONE (early termination).
REQ-019 TEST, lt = 1: bit k of trial is cleared.
REQ-020 TEST, gt = 1: bit k of trial is kept.
REQ-021 TEST, k > 0 and not eq: next trial = updated trial with bit k-1 set; k <= k-1; stay in TEST.
REQ-022 TEST, k = 0 and not eq: result <= updated trial -> DONE.
REQ-023 DONE: done = 1 for exactly one cycle -> IDLE unconditionally; busy = 0.
REQ-024 Latency: start sampled on edge 0; at most W TEST cycles; done is high no later than cycle W+1.
REQ-025 All arithmetic is unsigned W-bit; trial never exceeds 2^W - 1; no carries or overflow are possible.
REQ-026 start asserted in the DONE cycle is ignored; start in the following IDLE cycle is accepted (back-to-back spacing of 1 idle cycle).

Reset
REQ-027 While rst = 1 at a clock edge: state <= IDLE, trial <= 0, k <= W-1, result <= 0, err <= 0, busy = 0, done = 0.
REQ-028 rst overrides start and any in-progress TEST or DONE; the aborted search produces no done pulse.
REQ-029 The first start after rst deasserts is accepted normally.

Structure
REQ-030 The shared package sar_pkg holds the state enum (IDLE/TEST/DONE) and the default width constant.
REQ-031 No sub-module is instantiated: the comparator is external; the bench instantiates the team's N-bit structural comparator with a = target and b = trial.
REQ-032 The FSM uses a single registered state, with outputs decoded from state (Moore), except for the combinational flag sampling in TEST.

Verification
REQ-033 W=4, target 11, start -> trials 8, 12, 10, 11; eq on 11 -> result 11, err 0, done at cycle 5.
REQ-034 W=4, target 0 -> trials 8, 4, 2, 1, all lt, no eq -> result 0, done at cycle 5.
REQ-035 W=4, target 8 -> trial 8 eq on the first TEST -> result 8, done at cycle 2, busy high for 1 cycle.
REQ-036 Target 11, start pulsed again during TEST -> ignored; single done; result 11.
REQ-037 Bench forces gt = eq = 1 on the 2nd TEST -> err 1, result 0, done next cycle; the next start clears err.
REQ-038 rst asserted during the 3rd TEST -> next cycle IDLE, trial 0, no done; a new search on target 5 -> result 5.

Source files
------------

// File: rtl/sar_search_ctrl_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_pkg;

  localparam int unsigned SAR_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } sar_state_e;

  // Exactly one of the comparator flags may be asserted for a legal decision.
  function automatic logic flags_onehot(input logic gt, input logic eq, input logic lt);
    logic [2:0] f;
    f = {gt, eq, lt};
    return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
  endfunction

endpackage

// File: rtl/sar_search_ctrl_if.sv
// Handshake bundle between the search controller and the external comparator/user.
interface sar_search_ctrl_if import sar_pkg::*; #(
  parameter int W = SAR_W_DEFAULT
) ();

  logic         start;
  logic         gt;
  logic         eq;
  logic         lt;
  logic [W-1:0] trial;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;

  modport master (
    output start, gt, eq, lt,
    input  trial, busy, done, result, err
  );

  modport slave (
    input  start, gt, eq, lt,
    output trial, busy, done, result, err
  );

endinterface

// File: rtl/sar_search_ctrl.sv
// Binary search over a W-bit target using an external three-flag comparator,
// one bit decision per cycle, with early exit on equality.
module sar_search_ctrl import sar_pkg::*; #(
  parameter int W = SAR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  sar_search_ctrl_if.slave  bus
);

  localparam int KW = $clog2(W);
  localparam logic [KW-1:0] K_MSB     = KW'(W - 1);
  localparam logic [W-1:0]  TRIAL_ONE = W'(1);
  localparam logic [W-1:0]  TRIAL_MSB = {1'b1, {(W-1){1'b0}}};

  sar_state_e    state_q;
  logic [W-1:0]  trial_q;
  logic [KW-1:0] k_q;
  logic [W-1:0]  result_q;
  logic          err_q;
  logic          busy_q;
  logic          done_q;

  logic [W-1:0]  trial_upd_s;
  logic [W-1:0]  trial_d;
  logic          onehot_s;

  // Decision on the current trial: clear bit k on lt, then probe bit k-1.
  always_comb begin
    trial_upd_s = trial_q;
    trial_d     = trial_q;
    onehot_s    = flags_onehot(bus.gt, bus.eq, bus.lt);
    if (bus.lt) begin
      trial_upd_s = trial_q & ~(TRIAL_ONE << k_q);
    end else begin
      trial_upd_s = trial_q;
    end
    trial_d = trial_upd_s | (TRIAL_ONE << (k_q - KW'(1)));
  end

  // Controller FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      k_q      <= K_MSB;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q  <= TEST;
            trial_q  <= TRIAL_MSB;
            k_q      <= K_MSB;
            result_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
          end else begin
            trial_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        TEST: begin
          if (!onehot_s) begin
            err_q    <= 1'b1;
            result_q <= '0;
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else if (bus.eq) begin
            result_q <= trial_q;
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else if (k_q == KW'(0)) begin
            result_q <= trial_upd_s;
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            trial_q <= trial_d;
            k_q     <= k_q - KW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          trial_q <= '0;
          k_q     <= K_MSB;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          trial_q <= '0;
          k_q     <= K_MSB;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trial  = trial_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl: vector table, scoreboard on done,
// and hand-written sequences for restart, flag-error and reset-abort cases.
module tb_sar_search_ctrl;
  import sar_pkg::*;

  localparam int W = SAR_W_DEFAULT;

  typedef struct {
    logic [W-1:0] tgt;
    logic [W-1:0] res;
    logic         err;
    int           done_cyc;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] target;
  logic         force_en;
  int           tests = 0;
  int           fails = 0;
  exp_t         sb[$];
  vec_t         vecs[8];

  sar_search_ctrl_if #(.W(W)) bus();

  sar_search_ctrl #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Comparator model: a = target, b = trial; force_en injects an illegal gt+eq.
  always_comb begin
    if (force_en) begin
      bus.gt = 1'b1;
      bus.eq = 1'b1;
      bus.lt = 1'b0;
    end else begin
      bus.gt = (target > bus.trial);
      bus.eq = (target == bus.trial);
      bus.lt = (target < bus.trial);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Trial at step j is the target's top j bits with the next bit probed.
  function automatic logic [W-1:0] exp_trial(input logic [W-1:0] tgt, input int j);
    int t;
    int hi;
    t  = int'(tgt);
    hi = (t >> (W - j)) << (W - j);
    return W'(hi | (1 << (W - 1 - j)));
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending search.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=1 with no pending search, expected done=0 at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("sb_result", 32'(bus.result), 32'(e.res));
        check("sb_err", 32'(bus.err), 32'(e.err));
      end
    end
  end

  task automatic run_search(input logic [W-1:0] tgt, input logic [W-1:0] res, input logic err,
                            input int dcyc, input int restart_at, input int force_at,
                            input bit start_in_done);
    int cyc;
    int ntest;
    int got_done;
    target = tgt;
    @(negedge clk);
    bus.start = 1'b1;
    sb.push_back('{res: res, err: err});
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    ntest = 0;
    got_done = 0;
    check("accept_clears_err", 32'(bus.err), 32'd0);
    check("accept_clears_result", 32'(bus.result), 32'd0);
    while (cyc <= 3 * W && got_done == 0) begin
      bus.start = 1'b0;
      force_en = 1'b0;
      if (bus.done) begin
        got_done = cyc;
      end else begin
        if (bus.busy) begin
          check("trial", 32'(bus.trial), 32'(exp_trial(tgt, ntest)));
          if (ntest == restart_at) bus.start = 1'b1;
          if (ntest == force_at) force_en = 1'b1;
          ntest++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    force_en = 1'b0;
    if (got_done == 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: no done within %0d cycles, expected done at cycle %0d", 3 * W, dcyc);
    end else begin
      check("done_cycle", 32'(got_done), 32'(dcyc));
      check("busy_cycles", 32'(ntest), 32'(dcyc - 1));
    end
    if (start_in_done) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_single_pulse", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_trial", 32'(bus.trial), 32'd0);
    check("result_held", 32'(bus.result), 32'(res));
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b1;
    target = '0;
    force_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_trial", 32'(bus.trial), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);

    vecs[0] = '{tgt: 4'd11, res: 4'd11, err: 1'b0, done_cyc: 5};
    vecs[1] = '{tgt: 4'd0,  res: 4'd0,  err: 1'b0, done_cyc: 5};
    vecs[2] = '{tgt: 4'd8,  res: 4'd8,  err: 1'b0, done_cyc: 2};
    vecs[3] = '{tgt: 4'd15, res: 4'd15, err: 1'b0, done_cyc: 5};
    vecs[4] = '{tgt: 4'd4,  res: 4'd4,  err: 1'b0, done_cyc: 3};
    vecs[5] = '{tgt: 4'd1,  res: 4'd1,  err: 1'b0, done_cyc: 5};
    vecs[6] = '{tgt: 4'd6,  res: 4'd6,  err: 1'b0, done_cyc: 4};
    vecs[7] = '{tgt: 4'd12, res: 4'd12, err: 1'b0, done_cyc: 3};

    for (int i = 0; i < 8; i++) begin
      run_search(vecs[i].tgt, vecs[i].res, vecs[i].err, vecs[i].done_cyc, -1, -1, (i == 2));
    end

    // start pulsed mid-search is ignored
    run_search(4'd11, 4'd11, 1'b0, 5, 1, -1, 1'b0);
    // gt and eq together on the second decision
    run_search(4'd11, 4'd0, 1'b1, 3, -1, 1, 1'b0);
    run_search(4'd11, 4'd11, 1'b0, 5, -1, -1, 1'b0);

    // reset during the third decision aborts without a done pulse
    target = 4'd11;
    @(negedge clk);
    bus.start = 1'b1;
    sb.push_back('{res: 4'd11, err: 1'b0});
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    check("pre_rst_trial", 32'(bus.trial), 32'd10);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_trial", 32'(bus.trial), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_search(4'd5, 4'd5, 1'b0, 5, -1, -1, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
